// File: rtl/edge_pkg.sv
// Shared types and arithmetic for the edge magnitude frame buffer.
package edge_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_MAG = 1'b0;
    localparam logic MODE_THR = 1'b1;

    // |x| + |y| saturated to w bits; callers sign-extend their gradients to 32 bits.
    function automatic logic [31:0] abs_sat_add(input logic signed [31:0] x,
                                                input logic signed [31:0] y,
                                                input int w);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [31:0] lim;
        a   = x[31] ? 32'(-x) : 32'(x);
        b   = y[31] ? 32'(-y) : 32'(y);
        s   = a + b;
        lim = (32'd1 << w) - 32'd1;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/edge_magnitude_buffer_if.sv
// Gradient input stream and pixel output stream of the edge magnitude buffer.
interface edge_magnitude_buffer_if #(
    parameter int PIX_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] ud_data;
    logic [PIX_W-1:0] lr_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, ud_data, lr_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, ud_data, lr_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/edge_mag_unit.sv
// Combinational gradient magnitude with optional binary threshold.
module edge_mag_unit
    import edge_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] ud_data,
    input  logic [PIX_W-1:0] lr_data,
    input  logic             mode,
    input  logic [PIX_W-1:0] thresh,
    output logic [PIX_W-1:0] pix
);
    logic [PIX_W-1:0] mag;

    assign mag = PIX_W'(abs_sat_add(32'(signed'(ud_data)), 32'(signed'(lr_data)), PIX_W));

    always_comb begin
        pix = mag;
        if (mode == MODE_THR) begin
            pix = (mag >= thresh) ? '1 : '0;
        end else if (mode == MODE_MAG) begin
            pix = mag;
        end
    end
endmodule

// File: rtl/edge_magnitude_buffer.sv
// Frame buffer storing gradient magnitudes and draining them with backpressure.
//   state | meaning
//   LOAD  | accepting pixels into the buffer
//   HOLD  | frame complete or truncated, input stalled
//   DRAIN | streaming stored pixels out
module edge_magnitude_buffer
    import edge_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [PIX_W-1:0]  thresh,
    input  logic              drain,
    output logic              complete,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    edge_magnitude_buffer_if.slave bus
);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH-1);

    state_t           state, state_nx;
    logic             ready_q;
    logic             accept;
    logic             drain_empty;
    logic [ADDR_W:0]  cnt_inc;
    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]  rd_ptr;
    logic             rd_en;
    logic [PIX_W-1:0] ram_q;
    logic             s1_valid;
    logic             s1_last;
    logic             s1_move;
    logic             out_valid_q;
    logic             out_last_q;
    logic [PIX_W-1:0] out_data_q;
    logic             out_fire;
    logic             out_done;

    edge_mag_unit #(.PIX_W(PIX_W)) u_mag (
        .ud_data (bus.ud_data),
        .lr_data (bus.lr_data),
        .mode    (mode),
        .thresh  (thresh),
        .pix     (pix)
    );

    assign accept   = bus.in_valid & ready_q;
    assign cnt_inc  = count + {{ADDR_W{1'b0}}, accept};
    assign out_fire = out_valid_q & bus.out_ready;
    assign out_done = out_fire & out_last_q;

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // A beat accepted alongside drain belongs to the frame, so test the post-accept count.
    always_comb begin
        state_nx    = state;
        drain_empty = 1'b0;
        case (state)
            LOAD: begin
                if (drain) begin
                    if (cnt_inc != '0) begin
                        state_nx = DRAIN;
                    end else begin
                        drain_empty = 1'b1;
                    end
                end else if (accept && (bus.in_last || count == LAST_ADDR)) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (drain) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (out_done) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            complete <= 1'b0;
        end else begin
            ready_q  <= (state_nx == LOAD);
            complete <= out_done | drain_empty;
            if (out_done) begin
                count <= '0;
            end else if (accept) begin
                count <= cnt_inc;
            end
            if (accept && count == LAST_ADDR && !bus.in_last) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[count[ADDR_W-1:0]] <= pix;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    // RAM output acts as the prefetch stage; it only advances when the output stage frees up.
    assign s1_move = s1_valid & (~out_valid_q | bus.out_ready);
    assign rd_en   = (state == DRAIN) & (rd_ptr != count) & (~s1_valid | s1_move);

    always_ff @(posedge clk) begin
        if (reset || out_done) begin
            rd_ptr      <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr  <= rd_ptr + ONE;
                s1_last <= (rd_ptr == count - ONE);
            end
            if (rd_en) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
            if (s1_move) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ram_q;
                out_last_q  <= s1_last;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
